ifetch: RTL and testbench

Instruction fetch unit: producer side of the instruction-register path. Owns the PC, issues word reads on the instruction-memory port (read held until response), captures the returned word, and presents it with its PC to the decode stage (`ir` consumer) over a valid/ready handshake. Handles control-flow redirects, including one that arrives while a memory read is outstanding.

---
 rtl/ifetch_pkg.sv | 20 ++
 rtl/ifetch_pc_reg.sv | 32 +++
 rtl/ifetch.sv | 99 +++++++++
 tb/tb_ifetch.sv | 139 +++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared RV32I fetch types: FSM state encoding, machine word type and the PC increment.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2,
    HOLD    = 2'd3
  } ifetch_state_t;

  localparam rv32i_word PC_STEP = 32'd4;

  // Masking (rather than slicing) keeps every input bit in use.
  function automatic rv32i_word word_align(input rv32i_word addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/ifetch_pc_reg.sv
// Program counter: sync reset to RESET_PC, loads either pc+4 or an aligned redirect target.
module pc_reg
  import rv32i_types::*;
#(
  parameter rv32i_word RESET_PC = 32'h0000_0060
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        sel_redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic [31:0] pc_next
);

  // pc_next is exposed so the fetch FSM can latch the address it is about to request.
  always_comb begin
    pc_next = pc;
    if (load) begin
      pc_next = sel_redirect ? word_align(redirect_pc) : pc + PC_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch unit: issues held word reads, captures the word and hands it to decode
// over valid/ready, dropping wrong-path data across control-flow redirects.
module ifetch
  import rv32i_types::*;
#(
  parameter rv32i_word RESET_PC = 32'h0000_0060
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_count
);

  ifetch_state_t state, state_next;
  rv32i_word     req_addr;
  rv32i_word     pc, pc_next;
  logic          pc_load, pc_sel_redirect;
  logic          enter_fetch, capture;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk          (clk),
    .rst          (rst),
    .load         (pc_load),
    .sel_redirect (pc_sel_redirect),
    .redirect_pc  (redirect_pc),
    .pc           (pc),
    .pc_next      (pc_next)
  );

  assign imem_read    = (state == FETCH) || (state == DISCARD);
  assign imem_address = req_addr;
  assign instr_valid  = (state == HOLD) && !redirect;
  assign capture      = (state == FETCH) && imem_resp && !redirect;
  // Staying in FETCH while waiting is not an entry; only a completed read re-enters.
  assign enter_fetch  = (state_next == FETCH) && ((state != FETCH) || imem_resp);

  always_comb begin
    state_next      = state;
    pc_load         = 1'b0;
    pc_sel_redirect = 1'b1;
    case (state)
      IDLE: begin
        state_next = FETCH;
        pc_load    = redirect;
      end
      FETCH: begin
        if (imem_resp && !redirect) begin
          pc_load         = 1'b1;
          pc_sel_redirect = 1'b0;
          state_next      = HOLD;
        end else if (redirect) begin
          pc_load    = 1'b1;
          state_next = imem_resp ? FETCH : DISCARD;
        end
      end
      DISCARD: begin
        pc_load = redirect;
        if (imem_resp) state_next = FETCH;
      end
      HOLD: begin
        pc_load = redirect;
        if (redirect || instr_ready) state_next = FETCH;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req_addr    <= RESET_PC;
      instr_data  <= '0;
      instr_pc    <= '0;
      instr_count <= '0;
    end else begin
      state <= state_next;
      if (enter_fetch) req_addr <= pc_next;
      if (capture) begin
        instr_data <= imem_rdata;
        instr_pc   <= req_addr;
      end
      if (instr_valid && instr_ready) instr_count <= instr_count + 32'd1;
    end
  end

  // pc is only observed through pc_next; keep it referenced for lint.
  logic unused_pc;
  assign unused_pc = ^pc;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: a per-cycle vector table plus a hand-run slow-memory sequence.
module tb_ifetch;

  logic        clk = 1'b0;
  logic        rst, redirect, imem_resp, instr_ready;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_read, instr_valid;
  logic [31:0] imem_address, instr_data, instr_pc, instr_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rst, redirect, resp, ready, chk;
    logic [31:0] rpc, rdata;
    logic        e_read, e_valid;
    logic [31:0] e_addr, e_data, e_pc, e_cnt;
  } vec_t;

  vec_t vecs[$];

  ifetch #(.RESET_PC(32'h0000_0060)) dut (
    .clk          (clk),
    .rst          (rst),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_read    (imem_read),
    .imem_address (imem_address),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_data   (instr_data),
    .instr_pc     (instr_pc),
    .instr_count  (instr_count)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic r, input logic red, input logic [31:0] rpc,
                         input logic resp, input logic [31:0] rdata, input logic ready,
                         input logic chk, input logic e_read, input logic [31:0] e_addr,
                         input logic e_valid, input logic [31:0] e_data,
                         input logic [31:0] e_pc, input logic [31:0] e_cnt);
    vec_t v;
    v.rst = r; v.redirect = red; v.rpc = rpc; v.resp = resp; v.rdata = rdata;
    v.ready = ready; v.chk = chk; v.e_read = e_read; v.e_addr = e_addr;
    v.e_valid = e_valid; v.e_data = e_data; v.e_pc = e_pc; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  // Inputs are driven just after the falling edge; outputs sampled 1 time unit later.
  task automatic apply_vector(input vec_t v, input int idx);
    @(negedge clk);
    rst = v.rst; redirect = v.redirect; redirect_pc = v.rpc;
    imem_resp = v.resp; imem_rdata = v.rdata; instr_ready = v.ready;
    #1;
    if (v.chk) begin
      check_value($sformatf("v%0d imem_read", idx), {31'd0, imem_read}, {31'd0, v.e_read});
      check_value($sformatf("v%0d imem_address", idx), imem_address, v.e_addr);
      check_value($sformatf("v%0d instr_valid", idx), {31'd0, instr_valid}, {31'd0, v.e_valid});
      check_value($sformatf("v%0d instr_data", idx), instr_data, v.e_data);
      check_value($sformatf("v%0d instr_pc", idx), instr_pc, v.e_pc);
      check_value($sformatf("v%0d instr_count", idx), instr_count, v.e_cnt);
    end
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
    imem_resp = 1'b0; imem_rdata = '0; instr_ready = 1'b0;

    //      rst red rpc           resp rdata         rdy  chk rd addr          vld data          pc            cnt
    add_vec(1, 0, 32'h0,        0, 32'h0,        0,   0, 0, 32'h0,        0, 32'h0,        32'h0,        0); // 0
    add_vec(0, 0, 32'h0,        0, 32'h0,        1,   1, 0, 32'h60,       0, 32'h0,        32'h0,        0); // 1 reset state
    add_vec(0, 0, 32'h0,        1, 32'hA000_0000, 1,  1, 1, 32'h60,       0, 32'h0,        32'h0,        0);
    add_vec(0, 0, 32'h0,        0, 32'h0,        1,   1, 0, 32'h60,       1, 32'hA000_0000, 32'h60,      0);
    add_vec(0, 0, 32'h0,        1, 32'hA111_1111, 1,  1, 1, 32'h64,       0, 32'hA000_0000, 32'h60,      1);
    add_vec(0, 0, 32'h0,        0, 32'h0,        1,   1, 0, 32'h64,       1, 32'hA111_1111, 32'h64,      1);
    add_vec(0, 0, 32'h0,        1, 32'hA222_2222, 1,  1, 1, 32'h68,       0, 32'hA111_1111, 32'h64,      2);
    add_vec(0, 0, 32'h0,        0, 32'h0,        1,   1, 0, 32'h68,       1, 32'hA222_2222, 32'h68,      2);
    add_vec(0, 0, 32'h0,        1, 32'hA333_3333, 1,  1, 1, 32'h6C,       0, 32'hA222_2222, 32'h68,      3); // 8
    for (int i = 0; i < 5; i++)   // backpressure: held word stays, no read issued
      add_vec(0, 0, 32'h0,      0, 32'h0,        0,   1, 0, 32'h6C,       1, 32'hA333_3333, 32'h6C,      3);
    add_vec(0, 0, 32'h0,        0, 32'h0,        1,   1, 0, 32'h6C,       1, 32'hA333_3333, 32'h6C,      3); // 14
    add_vec(0, 0, 32'h0,        0, 32'h0,        1,   1, 1, 32'h70,       0, 32'hA333_3333, 32'h6C,      4);
    add_vec(0, 1, 32'h103,      0, 32'h0,        1,   1, 1, 32'h70,       0, 32'hA333_3333, 32'h6C,      4); // 16 redirect, read outstanding
    add_vec(0, 0, 32'h0,        1, 32'hDEAD_DEAD, 1,  1, 1, 32'h70,       0, 32'hA333_3333, 32'h6C,      4);
    add_vec(0, 0, 32'h0,        1, 32'hB000_0000, 1,  1, 1, 32'h100,      0, 32'hA333_3333, 32'h6C,      4);
    add_vec(0, 0, 32'h0,        0, 32'h0,        1,   1, 0, 32'h100,      1, 32'hB000_0000, 32'h100,     4);
    add_vec(0, 1, 32'h200,      1, 32'hBAD1_BAD1, 1,  1, 1, 32'h104,      0, 32'hB000_0000, 32'h100,     5); // 20 redirect with resp
    add_vec(0, 0, 32'h0,        1, 32'hB111_1111, 1,  1, 1, 32'h200,      0, 32'hB000_0000, 32'h100,     5);
    add_vec(0, 1, 32'h30,       0, 32'h0,        1,   1, 0, 32'h200,      0, 32'hB111_1111, 32'h200,     5); // 22 redirect with ready
    add_vec(0, 0, 32'h0,        1, 32'hB222_2222, 1,  1, 1, 32'h30,       0, 32'hB111_1111, 32'h200,     5);
    add_vec(0, 0, 32'h0,        0, 32'h0,        1,   1, 0, 32'h30,       1, 32'hB222_2222, 32'h30,      5);
    add_vec(0, 1, 32'h202,      0, 32'h0,        1,   1, 1, 32'h34,       0, 32'hB222_2222, 32'h30,      6); // 25
    add_vec(0, 0, 32'h0,        1, 32'hDEAD_0000, 1,  1, 1, 32'h34,       0, 32'hB222_2222, 32'h30,      6);
    add_vec(0, 0, 32'h0,        1, 32'hDEAD_1111, 1,  1, 1, 32'h200,      0, 32'hB222_2222, 32'h30,      6); // 27 rst next
    vecs[$].rst = 1'b1;
    add_vec(0, 0, 32'h0,        0, 32'h0,        1,   1, 0, 32'h60,       0, 32'h0,        32'h0,        0);
    add_vec(0, 0, 32'h0,        1, 32'hC000_0000, 1,  1, 1, 32'h60,       0, 32'h0,        32'h0,        0);
    add_vec(0, 1, 32'hFFFF_FFFE, 0, 32'h0,       0,   1, 0, 32'h60,       0, 32'hC000_0000, 32'h60,      0); // 30
    add_vec(0, 0, 32'h0,        1, 32'hC111_1111, 1,  1, 1, 32'hFFFF_FFFC, 0, 32'hC000_0000, 32'h60,     0);
    add_vec(0, 0, 32'h0,        0, 32'h0,        1,   1, 0, 32'hFFFF_FFFC, 1, 32'hC111_1111, 32'hFFFF_FFFC, 0);
    add_vec(0, 0, 32'h0,        0, 32'h0,        1,   1, 1, 32'h0,        0, 32'hC111_1111, 32'hFFFF_FFFC, 1); // wrap

    foreach (vecs[i]) apply_vector(vecs[i], i);

    // Slow memory: response on the 4th read cycle, valid the cycle after.
    @(negedge clk);
    rst = 1'b1; redirect = 1'b0; imem_resp = 1'b0; instr_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      imem_resp  = (i == 4);
      imem_rdata = (i == 4) ? 32'h1234_5678 : 32'h0;
      #1;
      check_value($sformatf("slow c%0d imem_read", i), {31'd0, imem_read},
                  {31'd0, (i >= 1 && i <= 4)});
      check_value($sformatf("slow c%0d imem_address", i), imem_address, 32'h60);
      check_value($sformatf("slow c%0d instr_valid", i), {31'd0, instr_valid}, {31'd0, (i == 5)});
      @(negedge clk);
    end
    check_value("slow instr_data", instr_data, 32'h1234_5678);
    check_value("slow instr_pc", instr_pc, 32'h60);
    check_value("slow instr_count", instr_count, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
